// File: rtl/apb_slave.sv
// APB register-bank slave: DEPTH x WIDTH registers at BASE_ADDR with error response and a sticky
// protocol-violation flag. Define APB_WAIT_STATE_EN to insert WAIT_CYCLES wait states per transfer.
module apb_slave #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 16,
    parameter logic [WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
    parameter int               WAIT_CYCLES = 2
) (
    input  logic             Hclk,
    input  logic             Hresetn,
    input  logic             Psel,
    input  logic             Penable,
    input  logic             Pwrite,
    input  logic [WIDTH-1:0] Paddr,
    input  logic [WIDTH-1:0] Pwdata,
    output logic [WIDTH-1:0] Prdata,
    output logic             Pready,
    output logic             Pslverr,
    output logic             proto_err,
    output logic [1:0]       fsm_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LSB   = IDX_W + 2;

    // Handshake: a transfer completes on the rising edge of an ACCESS cycle in which Pready=1;
    // Psel/Penable must stay high and Paddr/Pwrite stable while Pready=0, and the next transfer
    // may start (Psel=1, Penable=0) in that completing cycle without returning to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] addr_q;
    logic             write_q;
    logic [WIDTH-1:0] wdata_q;
    logic [WIDTH-1:0] bank [DEPTH];

    logic             addr_hit;
    logic [IDX_W-1:0] addr_idx;
    logic             waiting;
    logic             stall_err;
    logic             change_err;

    assign addr_hit  = (addr_q[WIDTH-1:LSB] == BASE_ADDR[WIDTH-1:LSB]) && (addr_q[1:0] == 2'b00);
    assign addr_idx  = addr_q[LSB-1:2];
    assign fsm_state = state;

`ifdef APB_WAIT_STATE_EN
    logic [3:0] wait_cnt;
    assign waiting = (state == ST_ACCESS) && (wait_cnt != 4'd0);
    assign Pready  = !Hresetn || !waiting;
`else
    assign waiting = 1'b0;
    assign Pready  = 1'b1;
`endif

    // A deasserted strobe during a wait state, or a changed address/direction while the master
    // still claims this access, aborts the transfer.
    assign stall_err  = waiting && (!Psel || !Penable);
    assign change_err = Psel && Penable && ((Paddr != addr_q) || (Pwrite != write_q));

    always_ff @(posedge Hclk) begin
        if (!Hresetn) begin
            state     <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            Prdata    <= '0;
            Pslverr   <= 1'b0;
            proto_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                bank[i] <= '0;
            end
`ifdef APB_WAIT_STATE_EN
            wait_cnt  <= 4'd0;
`endif
        end else begin
            Pslverr <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Penable) begin
                        proto_err <= 1'b1;
                    end
                    if (Psel && !Penable) begin
                        state   <= ST_SETUP;
                        addr_q  <= Paddr;
                        write_q <= Pwrite;
                        wdata_q <= Pwdata;
                    end
                end
                ST_SETUP: begin
                    if (Penable) begin
                        proto_err <= 1'b1;
                    end
                    state <= ST_ACCESS;
                    if (!addr_hit) begin
                        Prdata <= '0;
                    end else if (!write_q) begin
                        Prdata <= bank[addr_idx];
                    end
`ifdef APB_WAIT_STATE_EN
                    wait_cnt <= 4'(WAIT_CYCLES);
                    Pslverr  <= !addr_hit && (WAIT_CYCLES == 0);
`else
                    Pslverr  <= !addr_hit;
`endif
                end
                ST_ACCESS: begin
                    if (stall_err || change_err) begin
                        proto_err <= 1'b1;
                        state     <= ST_IDLE;
`ifdef APB_WAIT_STATE_EN
                        wait_cnt  <= 4'd0;
`endif
                    end else if (waiting) begin
`ifdef APB_WAIT_STATE_EN
                        wait_cnt <= wait_cnt - 4'd1;
                        // Error response is registered so it appears with the completing cycle.
                        if (wait_cnt == 4'd1) begin
                            Pslverr <= !addr_hit;
                        end
`endif
                    end else begin
                        if (write_q && addr_hit) begin
                            bank[addr_idx] <= wdata_q;
                        end
                        if (Psel && !Penable) begin
                            state   <= ST_SETUP;
                            addr_q  <= Paddr;
                            write_q <= Pwrite;
                            wdata_q <= Pwdata;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_slave.sv
// Self-checking bench for apb_slave: randomized APB transfers against an array model of the bank.
module tb_apb_slave;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          DEPTH = 16;
    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_SETUP  = 2'd1;
    localparam logic [1:0]  S_ACCESS = 2'd2;
`ifdef APB_WAIT_STATE_EN
    localparam int EXP_WAIT = 2;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xfer_t;

    logic        Hclk = 1'b0;
    logic        Hresetn;
    logic        Psel;
    logic        Penable;
    logic        Pwrite;
    logic [31:0] Paddr;
    logic [31:0] Pwdata;
    logic [31:0] Prdata;
    logic        Pready;
    logic        Pslverr;
    logic        proto_err;
    logic [1:0]  fsm_state;

    int          checks = 0;
    int          passes = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_prdata;
    logic        exp_proto;
    xfer_t       burst_q[$];

    apb_slave dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Psel      (Psel),
        .Penable   (Penable),
        .Pwrite    (Pwrite),
        .Paddr     (Paddr),
        .Pwdata    (Pwdata),
        .Prdata    (Prdata),
        .Pready    (Pready),
        .Pslverr   (Pslverr),
        .proto_err (proto_err),
        .fsm_state (fsm_state)
    );

    always #5 Hclk = ~Hclk;

    function automatic bit is_hit(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'(DEPTH * 4)) && (a[1:0] == 2'b00);
    endfunction

    function automatic int index_of(input logic [31:0] a);
        return int'((a - BASE) >> 2);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] idx;
        idx = 32'($urandom_range(0, DEPTH - 1));
        if ($urandom_range(0, 5) != 0) return BASE + idx * 4;
        case ($urandom_range(0, 2))
            0:       return BASE + 32'(DEPTH * 4) + idx * 4;
            1:       return BASE + idx * 4 + 32'($urandom_range(1, 3));
            default: return idx * 4;
        endcase
    endfunction

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        exp_prdata = '0;
        exp_proto  = 1'b0;
    endtask

    // Drives every transfer in burst_q back to back with Psel held high, checking each cycle.
    task automatic run_burst(input string tag);
        xfer_t cur;
        int    waits;
        int    idx;
        bit    done;
        bit    more;
        bit    hit;
        if (burst_q.size() == 0) return;
        cur = burst_q.pop_front();
        @(posedge Hclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = cur.wr; Paddr = cur.addr; Pwdata = cur.data;
        more = 1'b1;
        while (more) begin
            hit = is_hit(cur.addr);
            idx = index_of(cur.addr);
            @(posedge Hclk); #1;
            @(negedge Hclk);
            checks++;
            if (fsm_state !== S_SETUP) $display("FAIL %s setup_state: got %0d want %0d", tag, fsm_state, S_SETUP);
            else passes++;
            checks++;
            if (Pslverr !== 1'b0) $display("FAIL %s setup_slverr: got %b want 0", tag, Pslverr);
            else passes++;
            if (!hit) exp_prdata = '0;
            else if (!cur.wr) exp_prdata = model_mem[idx];
            @(posedge Hclk); #1;
            Penable = 1'b1;
            waits = 0;
            done  = 1'b0;
            while (!done) begin
                @(negedge Hclk);
                checks++;
                if (Prdata !== exp_prdata) $display("FAIL %s prdata addr=%h: got %h want %h", tag, cur.addr, Prdata, exp_prdata);
                else passes++;
                checks++;
                if (fsm_state !== S_ACCESS) $display("FAIL %s access_state: got %0d want %0d", tag, fsm_state, S_ACCESS);
                else passes++;
                if (Pready === 1'b1) begin
                    done = 1'b1;
                    checks++;
                    if (Pslverr !== logic'(!hit)) $display("FAIL %s slverr addr=%h: got %b want %b", tag, cur.addr, Pslverr, !hit);
                    else passes++;
                    checks++;
                    if (waits !== EXP_WAIT) $display("FAIL %s wait_states: got %0d want %0d", tag, waits, EXP_WAIT);
                    else passes++;
                    checks++;
                    if (proto_err !== exp_proto) $display("FAIL %s proto_err: got %b want %b", tag, proto_err, exp_proto);
                    else passes++;
                end else begin
                    checks++;
                    if (Pslverr !== 1'b0) $display("FAIL %s wait_slverr: got %b want 0", tag, Pslverr);
                    else passes++;
                    waits++;
                    if (waits > 20) begin
                        checks++;
                        $display("FAIL %s pready_timeout: got %0d wait cycles want %0d", tag, waits, EXP_WAIT);
                        done = 1'b1;
                    end
                end
            end
            if (cur.wr && hit) model_mem[idx] = cur.data;
            if (burst_q.size() > 0) begin
                cur = burst_q.pop_front();
                Penable = 1'b0; Pwrite = cur.wr; Paddr = cur.addr; Pwdata = cur.data;
            end else begin
                @(posedge Hclk); #1;
                Psel = 1'b0; Penable = 1'b0;
                more = 1'b0;
            end
        end
    endtask

    task automatic push_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
        xfer_t t;
        t.wr = wr; t.addr = addr; t.data = data;
        burst_q.push_back(t);
    endtask

    task automatic test_reset();
        Hresetn = 1'b0;
        repeat (2) @(posedge Hclk);
        @(negedge Hclk);
        checks++;
        if (fsm_state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE);
        else passes++;
        checks++;
        if (Prdata !== 32'h0) $display("FAIL reset_prdata: got %h want 0", Prdata);
        else passes++;
        checks++;
        if (Pslverr !== 1'b0) $display("FAIL reset_slverr: got %b want 0", Pslverr);
        else passes++;
        checks++;
        if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b want 0", proto_err);
        else passes++;
        checks++;
        if (Pready !== 1'b1) $display("FAIL reset_pready: got %b want 1", Pready);
        else passes++;
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        clear_model();
        for (int i = 0; i < DEPTH; i++) push_xfer(1'b0, BASE + 32'(i * 4), 32'h0);
        run_burst("reset_bank");
    endtask

    task automatic test_write_read();
        push_xfer(1'b1, 32'h8000_0008, 32'hDEAD_BEEF);
        run_burst("wr_deadbeef");
        push_xfer(1'b0, 32'h8000_0008, 32'h0);
        run_burst("rd_deadbeef");
    endtask

    task automatic test_error_response();
        push_xfer(1'b0, 32'h8000_0040, 32'h0);
        run_burst("rd_out_of_region");
        push_xfer(1'b1, 32'h8000_0002, 32'hFFFF_FFFF);
        run_burst("wr_misaligned");
        push_xfer(1'b0, 32'h8000_0000, 32'h0);
        push_xfer(1'b0, 32'h8000_0008, 32'h0);
        run_burst("rd_after_err");
    endtask

    task automatic test_back_to_back();
        push_xfer(1'b1, 32'h8000_000C, 32'h0000_1234);
        push_xfer(1'b0, 32'h8000_000C, 32'h0);
        push_xfer(1'b1, 32'h8000_0010, 32'hCAFE_F00D);
        push_xfer(1'b0, 32'h8000_0010, 32'h0);
        run_burst("back_to_back");
    endtask

    task automatic test_random();
        int n;
        for (int b = 0; b < 14; b++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) push_xfer(1'($urandom_range(0, 1)), rand_addr(), $urandom());
            run_burst("random");
            repeat ($urandom_range(0, 2)) @(posedge Hclk);
        end
        for (int i = 0; i < DEPTH; i++) push_xfer(1'b0, BASE + 32'(i * 4), 32'h0);
        run_burst("random_sweep");
    endtask

    task automatic test_proto_err();
        @(posedge Hclk); #1;
        Psel = 1'b1; Penable = 1'b1; Pwrite = 1'b0; Paddr = BASE;
        @(posedge Hclk); #1;
        Psel = 1'b0; Penable = 1'b0;
        exp_proto = 1'b1;
        @(negedge Hclk);
        checks++;
        if (proto_err !== 1'b1) $display("FAIL idle_penable_proto_err: got %b want 1", proto_err);
        else passes++;
        checks++;
        if (fsm_state !== S_IDLE) $display("FAIL idle_penable_state: got %0d want %0d", fsm_state, S_IDLE);
        else passes++;
        repeat (3) @(posedge Hclk);
        @(negedge Hclk);
        checks++;
        if (proto_err !== 1'b1) $display("FAIL proto_err_sticky: got %b want 1", proto_err);
        else passes++;
        push_xfer(1'b1, BASE + 32'd28, 32'h1111_7777);
        run_burst("pre_abort_write");
        @(posedge Hclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'd28; Pwdata = 32'hA5A5_0007;
        @(posedge Hclk); #1;
        @(posedge Hclk); #1;
        Penable = 1'b1; Paddr = BASE + 32'd24;
        @(posedge Hclk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(negedge Hclk);
        checks++;
        if (fsm_state !== S_IDLE) $display("FAIL abort_state: got %0d want %0d", fsm_state, S_IDLE);
        else passes++;
        checks++;
        if (proto_err !== 1'b1) $display("FAIL abort_proto_err: got %b want 1", proto_err);
        else passes++;
        push_xfer(1'b0, BASE + 32'd28, 32'h0);
        push_xfer(1'b0, BASE + 32'd24, 32'h0);
        run_burst("after_abort");
    endtask

    task automatic test_reset_mid_transfer();
        push_xfer(1'b1, BASE + 32'd20, 32'h0F0F_0F0F);
        run_burst("pre_reset_write");
        @(posedge Hclk); #1;
        Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'd20; Pwdata = 32'h5555_AAAA;
        @(posedge Hclk); #1;
        @(posedge Hclk); #1;
        Penable = 1'b1;
        Hresetn = 1'b0;
        @(posedge Hclk); #1;
        Psel = 1'b0; Penable = 1'b0;
        @(negedge Hclk);
        checks++;
        if (fsm_state !== S_IDLE) $display("FAIL midrst_state: got %0d want %0d", fsm_state, S_IDLE);
        else passes++;
        checks++;
        if (Pslverr !== 1'b0) $display("FAIL midrst_slverr: got %b want 0", Pslverr);
        else passes++;
        checks++;
        if (proto_err !== 1'b0) $display("FAIL midrst_proto_err: got %b want 0", proto_err);
        else passes++;
        checks++;
        if (Prdata !== 32'h0) $display("FAIL midrst_prdata: got %h want 0", Prdata);
        else passes++;
        @(posedge Hclk); #1;
        Hresetn = 1'b1;
        clear_model();
        push_xfer(1'b0, BASE + 32'd20, 32'h0);
        run_burst("midrst_readback");
    endtask

    initial begin
        Hresetn = 1'b0;
        Psel    = 1'b0;
        Penable = 1'b0;
        Pwrite  = 1'b0;
        Paddr   = '0;
        Pwdata  = '0;
        clear_model();
        test_reset();
        test_write_read();
        test_error_response();
        test_back_to_back();
        test_random();
        test_proto_err();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
